// File: rtl/id_exe_pipe_pkg.sv
// Shared widths, control payload and helpers for the ID/EX pipeline register.
package id_exe_pipe_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned REG_W    = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  // Decoded control bits carried from ID into EX
  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  // Register numbers seen by the forwarding unit and the hazard check
  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } regs_t;

  localparam ctrl_t CTRL_NOP = '0;
  localparam regs_t REGS_NOP = '0;

  // True when the write-back port is writing the register being read; r0 never matches
  function automatic logic wb_hit(input logic             we,
                                  input logic [REG_W-1:0] wb_rd,
                                  input logic [REG_W-1:0] src);
    return we && (wb_rd != ZERO_REG) && (wb_rd == src);
  endfunction

endpackage

// File: rtl/id_exe_pipe_if.sv
// Decode-side and execute-side signal bundle of the ID/EX pipeline register.
interface id_exe_pipe_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
);
  import id_exe_pipe_pkg::*;

  // Inputs from decode / write-back / pipeline control
  logic                hold;
  logic                flush;
  logic                id_valid;
  logic [DW-1:0]       id_pc;
  logic [DW-1:0]       id_rs_data;
  logic [DW-1:0]       id_rt_data;
  logic [DW-1:0]       id_imm;
  logic [REG_W-1:0]    id_rs;
  logic [REG_W-1:0]    id_rt;
  logic [REG_W-1:0]    id_rd;
  logic                id_uses_rs;
  logic                id_uses_rt;
  logic                id_RegWrite;
  logic                id_MemRead;
  logic                id_MemWrite;
  logic                id_MemtoReg;
  logic                id_ALUSrc;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic                wb_RegWrite;
  logic [REG_W-1:0]    wb_rd;
  logic [DW-1:0]       wb_data;

  // Outputs towards fetch (stall) and execute
  logic                stall;
  logic                id_exe_valid;
  logic [DW-1:0]       id_exe_pc;
  logic [DW-1:0]       id_exe_rs_data;
  logic [DW-1:0]       id_exe_rt_data;
  logic [DW-1:0]       id_exe_imm;
  logic [REG_W-1:0]    id_exe_rs;
  logic [REG_W-1:0]    id_exe_rt;
  logic [REG_W-1:0]    id_exe_rd;
  logic                id_exe_RegWrite;
  logic                id_exe_MemRead;
  logic                id_exe_MemWrite;
  logic                id_exe_MemtoReg;
  logic                id_exe_ALUSrc;
  logic [ALU_OP_W-1:0] id_exe_alu_op;
  logic [CW-1:0]       bubble_cnt;

  modport master (
    output hold, flush, id_valid, id_pc, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_alu_op,
           wb_RegWrite, wb_rd, wb_data,
    input  stall, id_exe_valid, id_exe_pc, id_exe_rs_data, id_exe_rt_data, id_exe_imm,
           id_exe_rs, id_exe_rt, id_exe_rd,
           id_exe_RegWrite, id_exe_MemRead, id_exe_MemWrite, id_exe_MemtoReg, id_exe_ALUSrc,
           id_exe_alu_op, bubble_cnt
  );

  modport slave (
    input  hold, flush, id_valid, id_pc, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_alu_op,
           wb_RegWrite, wb_rd, wb_data,
    output stall, id_exe_valid, id_exe_pc, id_exe_rs_data, id_exe_rt_data, id_exe_imm,
           id_exe_rs, id_exe_rt, id_exe_rd,
           id_exe_RegWrite, id_exe_MemRead, id_exe_MemWrite, id_exe_MemtoReg, id_exe_ALUSrc,
           id_exe_alu_op, bubble_cnt
  );

endinterface

// File: rtl/id_exe_pipe_load_use_detect.sv
// Combinational load-use compare between the load sitting in EX and the instruction in ID.
module id_exe_pipe_load_use_detect
  import id_exe_pipe_pkg::*;
(
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  output logic             hazard_o
);

  logic ex_is_load;
  logic rs_match;
  logic rt_match;

  // A load writing r0 can never create a dependency
  assign ex_is_load = ex_valid_i && ex_mem_read_i && (ex_rd_i != ZERO_REG);
  assign rs_match   = id_uses_rs_i && (id_rs_i == ex_rd_i);
  assign rt_match   = id_uses_rt_i && (id_rt_i == ex_rd_i);
  assign hazard_o   = ex_is_load && id_valid_i && (rs_match || rt_match);

endmodule

// File: rtl/id_exe_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and WB->ID bypass.
module id_exe_pipe
  import id_exe_pipe_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
) (
  input logic          clk,
  input logic          rst,
  id_exe_pipe_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          valid_q,   valid_d;
  ctrl_t         ctrl_q,    ctrl_d;
  regs_t         regs_q,    regs_d;
  logic [DW-1:0] pc_q,      pc_d;
  logic [DW-1:0] rs_data_q, rs_data_d;
  logic [DW-1:0] rt_data_q, rt_data_d;
  logic [DW-1:0] imm_q,     imm_d;
  logic [CW-1:0] cnt_q,     cnt_d;

  ctrl_t id_ctrl;
  regs_t id_regs;
  logic  hazard;
  logic  stall_c;

  assign id_ctrl = '{reg_write:  bus.id_RegWrite,
                     mem_read:   bus.id_MemRead,
                     mem_write:  bus.id_MemWrite,
                     mem_to_reg: bus.id_MemtoReg,
                     alu_src:    bus.id_ALUSrc,
                     alu_op:     bus.id_alu_op};
  assign id_regs = '{rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd};

  id_exe_pipe_load_use_detect u_load_use_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rd_i       (regs_q.rd),
    .id_valid_i    (bus.id_valid),
    .id_rs_i       (bus.id_rs),
    .id_rt_i       (bus.id_rt),
    .id_uses_rs_i  (bus.id_uses_rs),
    .id_uses_rt_i  (bus.id_uses_rt),
    .hazard_o      (hazard)
  );

  // A flush already kills the ID instruction, so it must not also freeze fetch
  assign stall_c = hazard && !bus.flush && !bus.hold;

  // Next-state: hold > flush > stall bubble > capture
  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    regs_d    = regs_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    cnt_d     = cnt_q;
    if (!bus.hold) begin
      if (bus.flush || stall_c) begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_NOP;
        regs_d  = REGS_NOP;
        if (stall_c && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        valid_d   = bus.id_valid;
        ctrl_d    = bus.id_valid ? id_ctrl : CTRL_NOP;
        regs_d    = bus.id_valid ? id_regs : REGS_NOP;
        pc_d      = bus.id_pc;
        imm_d     = bus.id_imm;
        rs_data_d = wb_hit(bus.wb_RegWrite, bus.wb_rd, bus.id_rs) ? bus.wb_data : bus.id_rs_data;
        rt_data_d = wb_hit(bus.wb_RegWrite, bus.wb_rd, bus.id_rt) ? bus.wb_data : bus.id_rt_data;
      end
    end
  end

  // Pipeline register bank and bubble counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= CTRL_NOP;
      regs_q    <= REGS_NOP;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      regs_q    <= regs_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.stall           = stall_c;
  assign bus.id_exe_valid    = valid_q;
  assign bus.id_exe_pc       = pc_q;
  assign bus.id_exe_rs_data  = rs_data_q;
  assign bus.id_exe_rt_data  = rt_data_q;
  assign bus.id_exe_imm      = imm_q;
  assign bus.id_exe_rs       = regs_q.rs;
  assign bus.id_exe_rt       = regs_q.rt;
  assign bus.id_exe_rd       = regs_q.rd;
  assign bus.id_exe_RegWrite = ctrl_q.reg_write;
  assign bus.id_exe_MemRead  = ctrl_q.mem_read;
  assign bus.id_exe_MemWrite = ctrl_q.mem_write;
  assign bus.id_exe_MemtoReg = ctrl_q.mem_to_reg;
  assign bus.id_exe_ALUSrc   = ctrl_q.alu_src;
  assign bus.id_exe_alu_op   = ctrl_q.alu_op;
  assign bus.bubble_cnt      = cnt_q;

endmodule

// File: tb/tb_id_exe_pipe.sv
// Self-checking bench for id_exe_pipe: directed scenarios then randomized traffic vs a reference model.
module tb_id_exe_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  id_exe_pipe_if #(.DW(DW), .CW(CW)) bus ();

  id_exe_pipe #(.DW(DW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of what EX should be holding
  logic        m_valid;
  logic [31:0] m_pc, m_rs_data, m_rt_data, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [8:0]  m_ctl;  // {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, alu_op[3:0]}
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_pc = '0; m_rs_data = '0; m_rt_data = '0; m_imm = '0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_ctl = '0; m_cnt = 0;
  endtask

  // Load-use rule evaluated on the model's EX contents and the current ID inputs
  function automatic logic model_hazard();
    logic ex_load;
    logic dep;
    ex_load = m_valid && m_ctl[7] && (m_rd != 5'd0);
    dep = (bus.id_uses_rs && bus.id_rs == m_rd) || (bus.id_uses_rt && bus.id_rt == m_rd);
    return ex_load && bus.id_valid && dep;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] rf_val);
    if (bus.wb_RegWrite && bus.wb_rd != 5'd0 && bus.wb_rd == src) return bus.wb_data;
    return rf_val;
  endfunction

  task automatic model_edge(input logic exp_stall);
    if (bus.hold) return;
    if (bus.flush || exp_stall) begin
      m_valid = 1'b0; m_ctl = '0; m_rs = '0; m_rt = '0; m_rd = '0;
      if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_valid   = bus.id_valid;
      m_pc      = bus.id_pc;
      m_imm     = bus.id_imm;
      m_rs_data = operand(bus.id_rs, bus.id_rs_data);
      m_rt_data = operand(bus.id_rt, bus.id_rt_data);
      if (bus.id_valid) begin
        m_ctl = {bus.id_RegWrite, bus.id_MemRead, bus.id_MemWrite, bus.id_MemtoReg,
                 bus.id_ALUSrc, bus.id_alu_op};
        m_rs = bus.id_rs; m_rt = bus.id_rt; m_rd = bus.id_rd;
      end else begin
        m_ctl = '0; m_rs = '0; m_rt = '0; m_rd = '0;
      end
    end
  endtask

  task automatic check_state();
    chk("valid",    32'(bus.id_exe_valid),    32'(m_valid));
    chk("RegWrite", 32'(bus.id_exe_RegWrite), 32'(m_ctl[8]));
    chk("MemRead",  32'(bus.id_exe_MemRead),  32'(m_ctl[7]));
    chk("MemWrite", 32'(bus.id_exe_MemWrite), 32'(m_ctl[6]));
    chk("MemtoReg", 32'(bus.id_exe_MemtoReg), 32'(m_ctl[5]));
    chk("ALUSrc",   32'(bus.id_exe_ALUSrc),   32'(m_ctl[4]));
    chk("alu_op",   32'(bus.id_exe_alu_op),   32'(m_ctl[3:0]));
    chk("rs",       32'(bus.id_exe_rs),       32'(m_rs));
    chk("rt",       32'(bus.id_exe_rt),       32'(m_rt));
    chk("rd",       32'(bus.id_exe_rd),       32'(m_rd));
    chk("bubble_cnt", 32'(bus.bubble_cnt),    32'(m_cnt));
    if (m_valid) begin
      chk("pc",      bus.id_exe_pc,      m_pc);
      chk("rs_data", bus.id_exe_rs_data, m_rs_data);
      chk("rt_data", bus.id_exe_rt_data, m_rt_data);
      chk("imm",     bus.id_exe_imm,     m_imm);
    end
  endtask

  // One clock: check stall before the edge, advance the model, check registers after it
  task automatic cycle();
    logic exp_stall;
    #1;
    exp_stall = model_hazard() && !bus.flush && !bus.hold;
    chk("stall", 32'(bus.stall), 32'(exp_stall));
    @(posedge clk);
    model_edge(exp_stall);
    #1;
    check_state();
  endtask

  task automatic idle();
    bus.hold = 0; bus.flush = 0; bus.id_valid = 0; bus.id_pc = '0;
    bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.id_RegWrite = 0; bus.id_MemRead = 0; bus.id_MemWrite = 0; bus.id_MemtoReg = 0;
    bus.id_ALUSrc = 0; bus.id_alu_op = '0;
    bus.wb_RegWrite = 0; bus.wb_rd = '0; bus.wb_data = '0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic urs, input logic urt, input logic mem_read);
    bus.id_valid = 1; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_uses_rs = urs; bus.id_uses_rt = urt;
    bus.id_RegWrite = 1; bus.id_MemRead = mem_read; bus.id_MemtoReg = mem_read;
    bus.id_ALUSrc = mem_read; bus.id_alu_op = mem_read ? 4'd2 : 4'd6;
    bus.id_pc = bus.id_pc + 32'd4;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    idle();
    model_reset();
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    check_state();

    // Plain capture
    bus.id_valid = 1; bus.id_pc = 32'h40; bus.id_rs = 3; bus.id_uses_rs = 1;
    bus.id_rs_data = 32'h11; bus.id_RegWrite = 1;
    cycle();
    chk("cap_pc", bus.id_exe_pc, 32'h40);
    chk("cap_rs_data", bus.id_exe_rs_data, 32'h11);
    chk("cap_RegWrite", 32'(bus.id_exe_RegWrite), 32'd1);

    // Load-use on rt: one bubble, then the dependent instruction
    instr(5'd1, 5'd0, 5'd5, 1, 0, 1);
    cycle();
    instr(5'd2, 5'd5, 5'd6, 1, 1, 0);
    #1 chk("lu_stall", 32'(bus.stall), 32'd1);
    cycle();
    chk("lu_bubble_valid", 32'(bus.id_exe_valid), 32'd0);
    chk("lu_cnt", 32'(bus.bubble_cnt), 32'd1);
    chk("lu_stall_drop", 32'(bus.stall), 32'd0);
    cycle();
    chk("lu_rt", 32'(bus.id_exe_rt), 32'd5);
    chk("lu_valid", 32'(bus.id_exe_valid), 32'd1);

    // No false stall: load to r0, and rt not actually read
    instr(5'd1, 5'd0, 5'd0, 1, 0, 1);
    cycle();
    instr(5'd0, 5'd2, 5'd3, 1, 1, 0);
    #1 chk("nfs_r0", 32'(bus.stall), 32'd0);
    cycle();
    instr(5'd1, 5'd0, 5'd5, 1, 0, 1);
    cycle();
    instr(5'd1, 5'd5, 5'd3, 1, 0, 0);
    #1 chk("nfs_unused_rt", 32'(bus.stall), 32'd0);
    cycle();

    // Flush concurrent with a hazard: single bubble, no stall, counter unchanged
    instr(5'd1, 5'd0, 5'd5, 1, 0, 1);
    cycle();
    instr(5'd2, 5'd5, 5'd6, 1, 1, 0);
    bus.flush = 1;
    #1 chk("flush_stall", 32'(bus.stall), 32'd0);
    cycle();
    chk("flush_valid", 32'(bus.id_exe_valid), 32'd0);
    chk("flush_RegWrite", 32'(bus.id_exe_RegWrite), 32'd0);
    chk("flush_alu_op", 32'(bus.id_exe_alu_op), 32'd0);
    chk("flush_cnt", 32'(bus.bubble_cnt), 32'd1);
    bus.flush = 0;

    // WB bypass, and no bypass of r0
    instr(5'd7, 5'd7, 5'd8, 1, 1, 0);
    bus.id_rs_data = 32'h1; bus.id_rt_data = 32'h2;
    bus.wb_RegWrite = 1; bus.wb_rd = 7; bus.wb_data = 32'hDEAD;
    cycle();
    chk("byp_rs", bus.id_exe_rs_data, 32'hDEAD);
    chk("byp_rt", bus.id_exe_rt_data, 32'hDEAD);
    instr(5'd0, 5'd0, 5'd8, 1, 1, 0);
    bus.wb_rd = 0;
    cycle();
    chk("nobyp_rs", bus.id_exe_rs_data, 32'h1);
    chk("nobyp_rt", bus.id_exe_rt_data, 32'h2);
    bus.wb_RegWrite = 0;

    // Hold freezes everything while ID keeps changing
    bus.id_pc = 32'hFC;
    instr(5'd3, 5'd4, 5'd9, 1, 1, 0);
    cycle();
    bus.hold = 1;
    for (int i = 0; i < 3; i++) begin
      instr(5'(i + 10), 5'(i + 11), 5'(i + 12), 1, 1, 1);
      bus.id_rs_data = $urandom;
      cycle();
      chk("hold_pc", bus.id_exe_pc, 32'h100);
      chk("hold_rd", 32'(bus.id_exe_rd), 32'd9);
    end
    bus.hold = 0;

    // Reset mid-stall: outputs clear before the next edge
    instr(5'd1, 5'd0, 5'd5, 1, 0, 1);
    cycle();
    instr(5'd2, 5'd5, 5'd6, 1, 1, 0);
    #1 chk("pre_rst_stall", 32'(bus.stall), 32'd1);
    rst = 1;
    #1;
    model_reset();
    check_state();
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_pc", bus.id_exe_pc, 32'd0);
    #1 rst = 0;
    cycle();

    // Saturation of the bubble counter
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      instr(5'd1, 5'd0, 5'd5, 1, 0, 1);
      cycle();
      instr(5'd2, 5'd5, 5'd6, 1, 1, 0);
      cycle();
    end
    chk("sat_cnt", 32'(bus.bubble_cnt), 32'(CNT_MAX));

    // Randomized traffic with narrow register range to provoke hazards and bypasses
    for (int i = 0; i < 400; i++) begin
      bus.hold        = ($urandom_range(0, 9) == 0);
      bus.flush       = ($urandom_range(0, 9) == 0);
      bus.id_valid    = ($urandom_range(0, 7) != 0);
      bus.id_pc       = $urandom;
      bus.id_rs_data  = $urandom;
      bus.id_rt_data  = $urandom;
      bus.id_imm      = $urandom;
      bus.id_rs       = 5'($urandom_range(0, 3));
      bus.id_rt       = 5'($urandom_range(0, 3));
      bus.id_rd       = 5'($urandom_range(0, 3));
      bus.id_uses_rs  = 1'($urandom);
      bus.id_uses_rt  = 1'($urandom);
      bus.id_RegWrite = 1'($urandom);
      bus.id_MemRead  = ($urandom_range(0, 4) < 2);
      bus.id_MemWrite = 1'($urandom);
      bus.id_MemtoReg = 1'($urandom);
      bus.id_ALUSrc   = 1'($urandom);
      bus.id_alu_op   = 4'($urandom);
      bus.wb_RegWrite = 1'($urandom);
      bus.wb_rd       = 5'($urandom_range(0, 3));
      bus.wb_data     = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_exe_pipe.md
# id_exe_pipe

ID/EX pipeline register for the five-stage MIPS-lite core, with integrated load-use hazard detection, bubble insertion, branch flush and a write-back-to-decode bypass. Sits between decode and execute. Its registered rs/rt/rd/RegWrite outputs feed the EX operand forwarding unit and the EX/MEM register. Its `stall` output freezes the PC and the IF/ID register.

## Interface
Parameters:
- `DW`, 32, datapath width (PC, operands, immediate)
- `CW`, 16, width of the load-use bubble counter

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `hold`  in  1  global pipeline freeze (memory wait); all state holds
- `flush`  in  1  branch/jump resolved taken in EX; kill the instruction in ID
- `id_valid`  in  1  ID holds a real instruction
- `id_pc`  in  DW  PC of the ID instruction
- `id_rs_data`, `id_rt_data`  in  DW  register-file read data
- `id_imm`  in  DW  extended immediate
- `id_rs`, `id_rt`, `id_rd`  in  5  source and destination register numbers (`id_rd` is after the RegDst mux)
- `id_uses_rs`, `id_uses_rt`  in  1  the instruction actually reads rs/rt
- `id_RegWrite`, `id_MemRead`, `id_MemWrite`, `id_MemtoReg`, `id_ALUSrc`  in  1  decoded controls
- `id_alu_op`  in  4  ALU operation
- `wb_RegWrite`  in  1  write-back write enable
- `wb_rd`  in  5  write-back destination
- `wb_data`  in  DW  write-back data
- `stall`  out  1  load-use stall: PC and IF/ID must not update
- `id_exe_valid`  out  1  registered valid
- `id_exe_pc`, `id_exe_rs_data`, `id_exe_rt_data`, `id_exe_imm`  out  DW  registered data
- `id_exe_rs`, `id_exe_rt`, `id_exe_rd`  out  5  registered register numbers
- `id_exe_RegWrite`, `id_exe_MemRead`, `id_exe_MemWrite`, `id_exe_MemtoReg`, `id_exe_ALUSrc`  out  1  registered controls
- `id_exe_alu_op`  out  4  registered ALU operation
- `bubble_cnt`  out  CW  saturating count of inserted load-use bubbles

## Operation
- Load-use hazard (combinational) is asserted when all of the following hold:
  - `id_exe_valid`, `id_exe_MemRead`, `id_valid`
  - `id_exe_rd != 0`
  - (`id_uses_rs` and `id_rs == id_exe_rd`) or (`id_uses_rt` and `id_rt == id_exe_rd`)
- `stall = hazard & ~flush & ~hold`.
- Per-edge action, in priority order:
  1. `hold`: every register holds. The counter holds.
  2. `flush`: load a bubble.
  3. `stall`: load a bubble. Increment `bubble_cnt`.
  4. Otherwise: capture all `id_*` fields. `id_exe_valid <= id_valid`.
- Bubble means:
  - `id_exe_valid`, all five control bits and `id_exe_alu_op` are 0.
  - `id_exe_rs`/`id_exe_rt`/`id_exe_rd` are 0, so the forwarding unit and this hazard check never match a bubble.
  - Data fields hold their previous value (don't-care).
- Capture with `id_valid=0` also zeroes the controls and register numbers, exactly like a bubble.
- Write-back bypass, on capture only:
  - If `wb_RegWrite`, `wb_rd != 0` and `wb_rd == id_rs`, capture `wb_data` into `id_exe_rs_data` instead of `id_rs_data`.
  - Same rule for rt.
  - Register 0 is never bypassed.
- `bubble_cnt` saturates at all-ones and never wraps.

## Timing
- Reset (asynchronous): every output register is 0, including `bubble_cnt`.
- `stall` follows its inputs within the same cycle (no registered delay).
- Capture latency: 1 cycle, from ID inputs to `id_exe_*`.
- Load-use produces exactly one bubble:
  - The cycle after the bubble is loaded, `id_exe_MemRead=0`, so `stall` drops.
  - The held ID instruction is then captured.
  - The forwarding unit supplies the load data from MEM/WB.
- Simultaneous `flush` and hazard: a single bubble, `stall=0`, counter unchanged.
- Simultaneous `hold` and `flush`: hold wins. The flush must be re-presented by its source while hold is high.
- `rst` asserted mid-stall: outputs clear immediately. `stall` goes to 0 because `id_exe_valid=0`.

## Structure
- Shared `head.v` gains:
  - ALU-op width macro (4)
  - register-number width (5)
  - `ZERO_REG` (5'd0)
- One natural sub-module: `load_use_detect` (combinational hazard compare). The register bank and bypass muxes stay in `id_exe_pipe`.

## Test plan
- Plain capture: `id_pc=0x40`, `id_rs=3`, `id_rs_data=0x11`, `id_RegWrite=1`, no hazard -> next cycle `id_exe_pc=0x40`, `id_exe_rs_data=0x11`, `id_exe_RegWrite=1`, `stall=0`.
- Load-use on rt:
  - Stimulus: EX holds `lw` with rd=5; ID instruction has rt=5, `id_uses_rt=1`.
  - Response: `stall=1` for exactly one cycle, next `id_exe_valid=0`, `bubble_cnt` 0->1.
  - Following cycle: ID captured with `id_exe_rt=5`.
- No false stall:
  - `lw` to r0 with ID rs=0 -> `stall=0`.
  - `lw` to r5 with ID `id_uses_rt=0`, rt=5 -> `stall=0`.
- Flush versus hazard:
  - Stimulus: load-use condition plus `flush=1`.
  - Response: `stall=0`, `id_exe_valid=0`, all controls 0, `bubble_cnt` unchanged.
- WB bypass: `wb_RegWrite=1`, `wb_rd=7`, `wb_data=0xDEAD`, `id_rs=id_rt=7`, `id_rs_data=0x1` -> `id_exe_rs_data=id_exe_rt_data=0xDEAD`. With `wb_rd=0`, no bypass.
- Hold and reset:
  - `hold=1` for 3 cycles with changing ID inputs -> outputs constant.
  - `rst` pulsed mid-cycle -> all outputs 0 before the next edge.
  - Counter preset near `2^CW-1` plus 2 hazards -> saturates at all-ones.
